// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//
// Shares one single-port instruction memory between the core's fetch port
// and a loader port. The two ports use a request/grant handshake, and one
// rule covers both:
//   - The requester raises *_req and holds req, address and write data stable
//     until it sees *_gnt high in the same cycle.
//   - The grant is combinational from the current requests and state.
//   - Exactly one cycle after a grant, *_rvalid pulses high for one cycle
//     with the response data.
//
// Arbitration:
//   - Fetch wins contended cycles until the loader has lost STARVE_MAX of
//     them in a row. The next contended cycle then goes to the loader.
//   - Misaligned or out-of-range accesses are still granted, so they
//     complete, but they never touch the memory. Fetch returns a NOP with
//     fetch_fault set. Loader returns load_err set.
//
// Optional feature (macro IMEM_LOADER_LOCK_EN):
//   - A loader grant taken with load_lock = 1 moves the arbiter to LOCKED.
//   - In LOCKED only the loader can be granted.
//   - LOCKED exits on the first cycle that load_lock is low.
//   - Without the macro, load_lock is ignored.
//
// Parameters:
//   IMEM_WORD  - memory depth in 32-bit words
//   STARVE_MAX - contended cycles the loader may lose before it must win
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   fetch_req/addr -> fetch_gnt     fetch request and grant
//   fetch_rvalid/rdata/fault        fetch response (one cycle after grant)
//   load_req/we/addr/wdata/lock     loader request
//   load_gnt                        loader grant
//   load_rvalid/rdata/err           loader response (one cycle after grant)
//   mem_en/we/addr/wdata            memory command
//   mem_rdata                       memory read data, valid one cycle after
//                                   mem_en
//   dbg_state                       current arbiter state (1 = LOCKED)
// ---------------------------------------------------------------------------
module imem_arbiter #(
    parameter int IMEM_WORD  = 4096,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    output logic        fetch_fault,
    input  logic        load_req,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata,
    input  logic        load_lock,
    output logic        load_gnt,
    output logic        load_rvalid,
    output logic [31:0] load_rdata,
    output logic        load_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        dbg_state
);

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] WORDS = 32'(IMEM_WORD);
    localparam int          CW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

`ifdef IMEM_LOADER_LOCK_EN
    typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;
`else
    typedef enum logic {ST_ARB = 1'b0} state_t;
    logic unused_lock;
    assign unused_lock = load_lock;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          fetch_bad, load_bad;

    // Response bookkeeping for the access granted in the previous cycle.
    logic          f_pend, f_fault, l_pend, l_err, l_wr;
    logic [31:0]   f_hold, l_hold;

    assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ({2'b00, fetch_addr[31:2]} >= WORDS);
    assign load_bad  = (load_addr[1:0]  != 2'b00) || ({2'b00, load_addr[31:2]}  >= WORDS);

    assign dbg_state = state_q;

    // Grant and next-state logic.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!reset) begin
            if (state_q == ST_ARB) begin
                if (fetch_req && load_req) begin
                    if (starve_q == STARVE_LIM) load_gnt  = 1'b1;
                    else                        fetch_gnt = 1'b1;
                end else if (fetch_req) begin
                    fetch_gnt = 1'b1;
                end else if (load_req) begin
                    load_gnt = 1'b1;
                end
`ifdef IMEM_LOADER_LOCK_EN
                if (load_gnt && load_lock) state_d = ST_LOCKED;
            end else begin
                load_gnt = load_req;
                if (!load_lock) state_d = ST_ARB;
`endif
            end

            // Only a contended cycle that the loader loses counts as starving.
            if (load_gnt) begin
                starve_d = '0;
            end else if (fetch_gnt && load_req && starve_q != STARVE_LIM) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Memory command.
    // Faulting accesses are granted but never reach the memory.
    always_comb begin
        mem_en    = (fetch_gnt && !fetch_bad) || (load_gnt && !load_bad);
        mem_we    = load_gnt && !load_bad && load_we;
        mem_addr  = load_gnt ? load_addr[31:2] : fetch_addr[31:2];
        mem_wdata = load_wdata;
    end

    // Responses.
    // The rdata outputs pass mem_rdata through in the response cycle.
    // Between responses they show the held copy of the last response.
    always_comb begin
        fetch_rvalid = f_pend;
        fetch_fault  = f_pend && f_fault;
        fetch_rdata  = f_pend ? (f_fault ? NOP : mem_rdata) : f_hold;
        load_rvalid  = l_pend;
        load_err     = l_pend && l_err;
        load_rdata   = l_pend ? ((l_err || l_wr) ? 32'h0 : mem_rdata) : l_hold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ARB;
            starve_q <= '0;
            f_pend   <= 1'b0;
            f_fault  <= 1'b0;
            l_pend   <= 1'b0;
            l_err    <= 1'b0;
            l_wr     <= 1'b0;
            f_hold   <= NOP;
            l_hold   <= 32'h0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            f_pend   <= fetch_gnt;
            f_fault  <= fetch_gnt && fetch_bad;
            l_pend   <= load_gnt;
            l_err    <= load_gnt && load_bad;
            l_wr     <= load_gnt && load_we;
            if (f_pend) f_hold <= fetch_rdata;
            if (l_pend) l_hold <= load_rdata;
        end
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter IMEM_WORD, default 4096, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter STARVE_MAX, default 8, the limit of consecutive contended cycles the loader may lose.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port fetch_req  in  1  fetch read request.
REQ-006 SHALL have port fetch_addr  in  32  fetch byte address.
REQ-007 SHALL have port fetch_gnt  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port fetch_rvalid / fetch_rdata / fetch_fault  out  1/32/1  fetch response.
REQ-009 SHALL have port load_req / load_we  in  1/1  loader request and write strobe.
REQ-010 SHALL have port load_addr / load_wdata  in  32/32  loader byte address and write data.
REQ-011 SHALL have port load_lock  in  1  loader burst-ownership request.
REQ-012 SHALL have port load_gnt / load_rvalid / load_rdata / load_err  out  1/1/32/1  loader grant and response.
REQ-013 SHALL have port mem_en / mem_we / mem_addr / mem_wdata  out  1/1/30/32  single-port memory command.
REQ-014 SHALL have port mem_rdata  in  32  memory read data, valid exactly 1 cycle after mem_en.

Function
REQ-015 SHALL, in state ARB, grant fetch when only fetch requests and grant loader when only loader requests.
REQ-016 SHALL, when both request in ARB, grant fetch unless starve_cnt == STARVE_MAX, in which case it grants loader.
REQ-017 SHALL increment starve_cnt, saturating at STARVE_MAX, on each contended cycle the loader loses, and clear it on any loader grant.
REQ-018 SHALL assert at most one grant per cycle; a grant is combinational from the current-cycle requests and state.
REQ-019 SHALL drive mem_addr = granted addr[31:2], with mem_en = 1 for a valid granted access and mem_we = load_we only for loader grants.
REQ-020 SHALL treat a fetch as faulting when fetch_addr[1:0] != 0 or fetch_addr[31:2] >= IMEM_WORD; a faulting fetch is granted with mem_en = 0.
REQ-021 SHALL, 1 cycle after a fetch grant, assert fetch_rvalid for 1 cycle with fetch_rdata = mem_rdata, or fetch_rdata = 0x00000013 and fetch_fault = 1 when faulting.
REQ-022 SHALL treat a loader access with an out-of-range or misaligned address as err: granted, mem_en = 0, then load_rvalid = 1 and load_err = 1 one cycle later.
REQ-023 SHALL, 1 cycle after a loader read grant, assert load_rvalid with load_rdata = mem_rdata; after a loader write, load_rvalid = 1 with load_rdata = 0.
REQ-024 SHALL hold fetch_rdata and load_rdata stable between responses; rvalid/fault/err are single-cycle pulses.
REQ-025 SHALL keep requests that are not granted un-consumed; the requester holds req/addr until its grant.

Reset
REQ-026 SHALL, while reset = 1, force state ARB, starve_cnt = 0, all grants/rvalid/fault/err = 0, mem_en = mem_we = 0, and rdata outputs = 0x00000013 (fetch) / 0 (load).
REQ-027 SHALL discard any response pending when reset asserts mid-operation; no rvalid appears after reset deasserts without a new grant.

Configuration
REQ-028 SHALL, with IMEM_LOADER_LOCK_EN defined, enter state LOCKED on a loader grant while load_lock = 1; in LOCKED only the loader is granted, fetch_gnt = 0, and return to ARB occurs on the first cycle load_lock = 0.
REQ-029 SHALL, with IMEM_LOADER_LOCK_EN undefined, ignore load_lock, omit the LOCKED state, and arbitrate only per REQ-015..017.

Verification
REQ-030 SHALL cover: fetch_req = 1, addr 0x10, mem word4 = 0xDEADBEEF -> gnt cycle n, fetch_rvalid cycle n+1, rdata 0xDEADBEEF.
REQ-031 SHALL cover: fetch_addr = 4*IMEM_WORD -> mem_en = 0, fetch_fault = 1, rdata 0x00000013 next cycle; addr 0x2 -> same.
REQ-032 SHALL cover: both requesting continuously -> fetch wins 8 cycles, loader granted on 9th, counter cleared, fetch wins next.
REQ-033 SHALL cover: loader write 0x12345678 to 0x40 then fetch 0x40 -> fetch_rdata 0x12345678.
REQ-034 SHALL cover: with IMEM_LOADER_LOCK_EN defined, load_lock = 1 for 5 loader writes with fetch_req = 1 -> fetch_gnt = 0 throughout, fetch granted the cycle after lock drops.
REQ-035 SHALL cover: reset asserted the cycle after a grant -> no rvalid, all outputs at reset values.
